// File: rtl/multicycle_sequencer.sv
// Purpose : multicycle RV32I control FSM that shares one memory port between fetch and data access.
//           It also counts retired instructions.
// Latency : 3 cycles for ALU/jump/branch/U-type, 4 for a store and 5 for a load with zero-wait memory.
// Backpressure: FETCH and MEM hold with mem_req stable until the cycle in which mem_ack is high.
// Ports   : clk/reset_n (async active-low); op/funct3/funct7_5 come from the IR; br_taken comes from the
//           comparator; mem_ack completes a request; mem_req/mem_we/iord drive the memory port;
//           ir_we/pc_we/pcsel/regwrite/wbsel/alusrc/alucontrol/alu_sub drive the datapath;
//           illegal_op pulses on an unsupported opcode; instret is the retired-instruction count.
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pcsel,
  output logic             regwrite,
  output logic [2:0]       wbsel,
  output logic             alusrc,
  output logic [2:0]       alucontrol,
  output logic             alu_sub,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic             r_mem_req;
  logic             r_iord;
  logic             r_mem_we;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (op)
      OP_R, OP_LD, OP_ST, OP_I, OP_BR, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Next state plus the enables that depend on mem_ack or br_taken in the current cycle.
  always_comb begin
    w_nxt      = r_state;
    w_retire   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pcsel      = 2'b00;
    regwrite   = 1'b0;
    wbsel      = 3'b000;
    alusrc     = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_IDLE: w_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_we = 1'b1;
          w_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_nxt = S_EXEC;
        end else begin
          // Skip the bad word: advance PC but do not count it as retired.
          illegal_op = 1'b1;
          pc_we      = 1'b1;
          w_nxt      = S_FETCH;
        end
      end
      S_EXEC: begin
        w_retire = 1'b1;
        case (op)
          OP_R:     regwrite = 1'b1;
          OP_I:     begin regwrite = 1'b1; alusrc = 1'b1; end
          OP_LUI:   begin regwrite = 1'b1; wbsel = 3'b011; end
          OP_AUIPC: begin regwrite = 1'b1; wbsel = 3'b100; end
          OP_JAL:   begin regwrite = 1'b1; wbsel = 3'b010; pcsel = 2'b10; end
          OP_JALR:  begin regwrite = 1'b1; wbsel = 3'b010; pcsel = 2'b11; alusrc = 1'b1; end
          OP_BR:    pcsel = br_taken ? 2'b01 : 2'b00;
          OP_LD, OP_ST: begin
            w_retire = 1'b0;
            alusrc   = 1'b1;
            w_nxt    = S_MEM;
          end
          default: begin
            // DECODE only lets legal opcodes through; recover by refetching.
            w_retire = 1'b0;
            w_nxt    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        alusrc = 1'b1;
        if (mem_ack) begin
          if (op == OP_ST) w_retire = 1'b1;
          else             w_nxt    = S_WB;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        wbsel    = 3'b001;
        w_retire = 1'b1;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_retire) begin
      pc_we = 1'b1;
      w_nxt = S_FETCH;
    end
  end

  // ALU control follows the IR in every state except IDLE, which keeps all outputs low.
  always_comb begin
    alucontrol = 3'b000;
    alu_sub    = 1'b0;
    if (r_state != S_IDLE) begin
      case (op)
        OP_R:  begin alucontrol = funct3; alu_sub = funct7_5; end
        OP_I:  begin alucontrol = funct3; alu_sub = funct7_5 && (funct3 == 3'b101); end
        OP_BR: alu_sub = 1'b1;
        default: ;
      endcase
    end
  end

  // Memory port controls are registered from the next state, so they stay glitch-free and
  // stable for the whole request. Async reset drops them immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_mem_req <= 1'b0;
      r_iord    <= 1'b0;
      r_mem_we  <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state   <= w_nxt;
      r_mem_req <= (w_nxt == S_FETCH) || (w_nxt == S_MEM);
      r_iord    <= (w_nxt == S_MEM);
      r_mem_we  <= (w_nxt == S_MEM) && (op == OP_ST);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign mem_req = r_mem_req;
  assign iord    = r_iord;
  assign mem_we  = r_mem_we;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
  localparam int CNT_W = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             br_taken;
  logic             mem_ack;
  logic             mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]       pcsel;
  logic             regwrite;
  logic [2:0]       wbsel;
  logic             alusrc;
  logic [2:0]       alucontrol;
  logic             alu_sub;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .br_taken(br_taken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pcsel(pcsel), .regwrite(regwrite),
    .wbsel(wbsel), .alusrc(alusrc), .alucontrol(alucontrol), .alu_sub(alu_sub),
    .illegal_op(illegal_op), .instret(instret)
  );

  typedef struct {
    logic [1:0] pcsel;
    logic       regwrite;
    logic [2:0] wbsel;
    logic       alusrc;
    logic [2:0] alu;
    logic       sub;
    logic       ill;
    int         cyc;
  } exp_t;

  exp_t             sb[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] exp_instret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge that put the DUT in FETCH; returns just after the edge that
  // brings it back to FETCH. fw/mw are wait cycles before ack in FETCH/MEM.
  task automatic do_instr(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic brt, input int fw, input int mw, input exp_t e);
    int   cyc, cnt, n_ill;
    logic done, saw_mem;
    exp_t got;
    sb.push_back(e);
    op = o; funct3 = f3; funct7_5 = f7; br_taken = brt;
    cyc = 0; cnt = 0; n_ill = 0; done = 1'b0; saw_mem = 1'b0;
    while (!done && cyc < 64) begin
      // Ack is driven high outside requests to show it is ignored there.
      mem_ack = mem_req ? (cnt == (iord ? mw : fw)) : 1'b1;
      #1;
      cyc++;
      if (cyc == 1) chk({nm, ".fetch_req"}, {mem_req, iord}, 2'b10);
      if (mem_req) begin
        chk({nm, ".mem_we"}, mem_we, iord && (o == OP_ST));
        if (iord) saw_mem = 1'b1;
        if (mem_ack) cnt = 0; else cnt++;
      end
      if (illegal_op) n_ill++;
      if (pc_we) begin
        done = 1'b1;
        if (sb.size() == 0) chk({nm, ".sb_underflow"}, 0, 1);
        else begin
          got = sb.pop_front();
          chk({nm, ".pcsel"},    pcsel,      got.pcsel);
          chk({nm, ".regwrite"}, regwrite,   got.regwrite);
          chk({nm, ".wbsel"},    wbsel,      got.wbsel);
          chk({nm, ".alusrc"},   alusrc,     got.alusrc);
          chk({nm, ".aluctl"},   alucontrol, got.alu);
          chk({nm, ".alu_sub"},  alu_sub,    got.sub);
          chk({nm, ".cycles"},   cyc,        got.cyc);
          chk({nm, ".n_illegal"}, n_ill,     got.ill ? 1 : 0);
          if (!got.ill) exp_instret = exp_instret + 1'b1;
        end
      end
      @(posedge clk); #2;
    end
    mem_ack = 1'b0;
    chk({nm, ".done"}, done, 1'b1);
    chk({nm, ".mem_phase"}, saw_mem, (o == OP_LD) || (o == OP_ST));
    chk({nm, ".instret"}, instret, exp_instret);
    chk({nm, ".back_fetch"}, {mem_req, iord}, 2'b10);
  endtask

  function automatic exp_t mk(input logic [1:0] ps, input logic rw, input logic [2:0] wb, input logic as,
                              input logic [2:0] al, input logic sb_, input logic il, input int cy);
    exp_t e;
    e.pcsel = ps; e.regwrite = rw; e.wbsel = wb; e.alusrc = as;
    e.alu = al; e.sub = sb_; e.ill = il; e.cyc = cy;
    return e;
  endfunction

  initial begin
    logic [2:0] rf3;
    logic       rf7;
    int         rfw;
    int         guard;
    reset_n = 1'b0; op = OP_R; funct3 = 3'b000; funct7_5 = 1'b1; br_taken = 1'b0; mem_ack = 1'b1;
    #12;
    chk("rst.mem_port", {mem_req, mem_we, iord}, 3'b000);
    chk("rst.enables", {ir_we, pc_we, regwrite, alusrc, illegal_op}, 5'b0);
    chk("rst.selects", {pcsel, wbsel, alucontrol, alu_sub}, 9'b0);
    chk("rst.instret", instret, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1; chk("rel.idle_cycle1", {mem_req, ir_we}, 2'b00);
    @(posedge clk); #2;

    do_instr("sub",    OP_R,     3'b000, 1'b1, 1'b0, 0, 0, mk(2'b00, 1, 3'b000, 0, 3'b000, 1, 0, 3));
    do_instr("load",   OP_LD,    3'b010, 1'b0, 1'b0, 3, 3, mk(2'b00, 1, 3'b001, 0, 3'b000, 0, 0, 11));
    do_instr("br_t",   OP_BR,    3'b000, 1'b0, 1'b1, 0, 0, mk(2'b01, 0, 3'b000, 0, 3'b000, 1, 0, 3));
    do_instr("br_nt",  OP_BR,    3'b001, 1'b0, 1'b0, 0, 0, mk(2'b00, 0, 3'b000, 0, 3'b000, 1, 0, 3));
    do_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, mk(2'b00, 0, 3'b000, 0, 3'b000, 0, 1, 2));
    do_instr("slli",   OP_I,     3'b001, 1'b1, 1'b0, 0, 0, mk(2'b00, 1, 3'b000, 1, 3'b001, 0, 0, 3));
    do_instr("srai",   OP_I,     3'b101, 1'b1, 1'b0, 0, 0, mk(2'b00, 1, 3'b000, 1, 3'b101, 1, 0, 3));
    do_instr("store",  OP_ST,    3'b010, 1'b0, 1'b0, 0, 0, mk(2'b00, 0, 3'b000, 1, 3'b000, 0, 0, 4));
    do_instr("store_w", OP_ST,   3'b010, 1'b0, 1'b0, 2, 1, mk(2'b00, 0, 3'b000, 1, 3'b000, 0, 0, 7));
    do_instr("jal",    OP_JAL,   3'b000, 1'b0, 1'b0, 0, 0, mk(2'b10, 1, 3'b010, 0, 3'b000, 0, 0, 3));
    do_instr("jalr",   OP_JALR,  3'b000, 1'b0, 1'b0, 1, 0, mk(2'b11, 1, 3'b010, 1, 3'b000, 0, 0, 4));
    do_instr("lui",    OP_LUI,   3'b000, 1'b0, 1'b0, 0, 0, mk(2'b00, 1, 3'b011, 0, 3'b000, 0, 0, 3));
    do_instr("auipc",  OP_AUIPC, 3'b000, 1'b0, 1'b0, 0, 0, mk(2'b00, 1, 3'b100, 0, 3'b000, 0, 0, 3));

    // Enough ALU ops to wrap the narrow retired counter.
    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rf7 = 1'($urandom_range(0, 1));
      rfw = $urandom_range(0, 2);
      if (i % 2 == 0)
        do_instr("rnd_i", OP_I, rf3, rf7, 1'b0, rfw, 0,
                 mk(2'b00, 1, 3'b000, 1, rf3, (rf3 == 3'b101) && rf7, 0, 3 + rfw));
      else
        do_instr("rnd_r", OP_R, rf3, rf7, 1'b0, rfw, 0,
                 mk(2'b00, 1, 3'b000, 0, rf3, rf7, 0, 3 + rfw));
    end

    // Reset in the middle of a store that is waiting in MEM.
    op = OP_ST; funct3 = 3'b010; funct7_5 = 1'b0;
    guard = 0;
    while (!(mem_req && iord) && guard < 20) begin
      mem_ack = 1'b1;
      @(posedge clk); #2;
      guard++;
    end
    mem_ack = 1'b0;
    chk("rst_mid.reached_mem", {mem_req, iord, mem_we}, 3'b111);
    repeat (2) begin @(posedge clk); #2; end
    chk("rst_mid.still_waiting", {mem_req, mem_we, pc_we}, 3'b110);
    #1; reset_n = 1'b0;
    #1;
    chk("rst_mid.drop", {mem_req, mem_we, iord, pc_we, regwrite}, 5'b0);
    chk("rst_mid.instret", instret, 0);
    exp_instret = '0;
    @(negedge clk); reset_n = 1'b1;
    #1; chk("rst_mid.idle", mem_req, 1'b0);
    @(posedge clk); #2;
    chk("rst_mid.fetch", {mem_req, iord, mem_we}, 3'b100);
    do_instr("post_rst", OP_R, 3'b111, 1'b0, 1'b0, 0, 0, mk(2'b00, 1, 3'b000, 0, 3'b111, 0, 0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
